// File: rtl/trace_pkg.sv
// +-----------------------------------------------------------------+
// | trace_pkg : state encoding and entry layout for bus_trace_buffer |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package trace_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Entry layout is {sync, rw, a, d} with d at the LSB end.
  localparam int D_LSB = 0;

  function automatic int a_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int rw_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int sync_bit(input int addr_w, input int data_w);
    return addr_w + data_w + 1;
  endfunction

  function automatic int entry_w(input int addr_w, input int data_w);
    return addr_w + data_w + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_trig_cmp.sv
// +-----------------------------------------------------------------+
// | trace_trig_cmp : one mask/pattern address comparator, SYNC-gated |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module trace_trig_cmp #(
  parameter int ADDR_W = 16
) (
  input  logic              en,
  input  logic              sync_only,
  input  logic              sync,
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] mask,
  input  logic [ADDR_W-1:0] pat,
  output logic              match
);

  assign match = en && (((a ^ pat) & mask) == '0) && (!sync_only || sync);

endmodule

`default_nettype wire

// File: rtl/bus_trace_buffer.sv
// +-----------------------------------------------------------------+
// | bus_trace_buffer : 6502 bus-cycle trace RAM with address triggers|
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module bus_trace_buffer
  import trace_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 6,
  parameter int N_TRIG     = 2
) (
  input  logic                             CLK25MHZ,
  input  logic                             rst_n,
  input  logic                             phi2,
  input  logic [ADDR_W-1:0]                a,
  input  logic [DATA_W-1:0]                d,
  input  logic                             rw,
  input  logic                             sync,
  input  logic                             arm,
  input  logic                             clear,
  input  logic                             force_trig,
  input  logic [DEPTH_LOG2-1:0]            post_len,
  input  logic [N_TRIG-1:0]                trig_en,
  input  logic [N_TRIG-1:0]                trig_sync_only,
  input  logic [N_TRIG*ADDR_W-1:0]         trig_mask,
  input  logic [N_TRIG*ADDR_W-1:0]         trig_pat,
  input  logic [DEPTH_LOG2-1:0]            rd_idx,
  output logic [ADDR_W+DATA_W+1:0]         rd_data,
  output logic [DEPTH_LOG2:0]              count,
  output logic [N_TRIG-1:0]                trig_hit,
  output logic [1:0]                       state,
  output logic                             done
);

  localparam int c_EW       = entry_w(ADDR_W, DATA_W);
  localparam int c_DEPTH    = 2 ** DEPTH_LOG2;
  localparam int c_D_LSB    = D_LSB;
  localparam int c_A_LSB    = a_lsb(DATA_W);
  localparam int c_RW_BIT   = rw_bit(ADDR_W, DATA_W);
  localparam int c_SYNC_BIT = sync_bit(ADDR_W, DATA_W);
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   c_CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   c_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic                  r_phi2_d;
  logic                  w_samp;
  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2-1:0] r_post_cnt;
  logic [N_TRIG-1:0]     r_trig_hit;
  logic [N_TRIG-1:0]     w_match;
  logic                  w_any_match;
  logic                  w_we;
  logic [c_EW-1:0]       w_entry;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic [c_EW-1:0]       r_mem [c_DEPTH];
  logic [c_EW-1:0]       r_ram_q;
  logic                  r_rd_ok;

  for (genvar gi = 0; gi < N_TRIG; gi++) begin : g_trig
    trace_trig_cmp #(.ADDR_W(ADDR_W)) u_cmp (
      .en        (trig_en[gi]),
      .sync_only (trig_sync_only[gi]),
      .sync      (sync),
      .a         (a),
      .mask      (trig_mask[gi*ADDR_W +: ADDR_W]),
      .pat       (trig_pat[gi*ADDR_W +: ADDR_W]),
      .match     (w_match[gi])
    );
  end

  assign w_samp      = r_phi2_d && !phi2;
  assign w_any_match = |w_match;

  always_comb begin
    w_entry                     = '0;
    w_entry[c_D_LSB +: DATA_W]  = d;
    w_entry[c_A_LSB +: ADDR_W]  = a;
    w_entry[c_RW_BIT]           = rw;
    w_entry[c_SYNC_BIT]         = sync;
  end

  always_ff @(posedge CLK25MHZ or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else if (arm) begin
      w_state_nxt = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED: if ((w_samp && w_any_match) || force_trig)
                    w_state_nxt = (post_len == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (w_samp && r_post_cnt == c_PTR_ONE)
                    w_state_nxt = ST_DONE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // A pulse of arm or clear preempts any write in the same cycle.
  always_comb begin
    done = (r_state == ST_DONE);
    w_we = w_samp && !clear && !arm &&
           (r_state == ST_ARMED || r_state == ST_POST);
  end

  always_ff @(posedge CLK25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_phi2_d   <= 1'b0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_post_cnt <= '0;
      r_trig_hit <= '0;
      r_rd_ok    <= 1'b0;
    end else begin
      r_phi2_d <= phi2;
      r_rd_ok  <= ({1'b0, rd_idx} < r_count);
      if (clear) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (arm) begin
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_trig_hit <= '0;
      end else begin
        if (w_we) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
          if (r_count != c_FULL) r_count <= r_count + c_CNT_ONE;
        end
        // A matching sample takes priority over a coincident manual trigger.
        if (r_state == ST_ARMED) begin
          if (w_samp && w_any_match) begin
            r_trig_hit <= w_match;
            r_post_cnt <= post_len;
          end else if (force_trig) begin
            r_trig_hit <= '0;
            r_post_cnt <= post_len;
          end
        end else if (r_state == ST_POST && w_samp) begin
          r_post_cnt <= r_post_cnt - c_PTR_ONE;
        end
      end
    end
  end

  assign w_rd_addr = r_wr_ptr - r_count[DEPTH_LOG2-1:0] + rd_idx;

  // Non-blocking read gives old data on a same-address write.
  always_ff @(posedge CLK25MHZ) begin
    if (w_we) r_mem[r_wr_ptr] <= w_entry;
    r_ram_q <= r_mem[w_rd_addr];
  end

  assign rd_data  = r_rd_ok ? r_ram_q : '0;
  assign count    = r_count;
  assign trig_hit = r_trig_hit;
  assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_bus_trace_buffer.sv
// +-----------------------------------------------------------------+
// | tb_bus_trace_buffer : scoreboard bench with queue-based model    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_bus_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phi2;
  logic [15:0] a;
  logic [7:0]  d;
  logic        rw;
  logic        sync;
  logic        arm;
  logic        clear;
  logic        force_trig;
  logic [5:0]  post_len;
  logic [1:0]  trig_en;
  logic [1:0]  trig_sync_only;
  logic [31:0] trig_mask;
  logic [31:0] trig_pat;
  logic [5:0]  rd_idx;
  logic [25:0] rd_data;
  logic [6:0]  count;
  logic [1:0]  trig_hit;
  logic [1:0]  state;
  logic        done;

  bus_trace_buffer dut (
    .CLK25MHZ       (clk),
    .rst_n          (rst_n),
    .phi2           (phi2),
    .a              (a),
    .d              (d),
    .rw             (rw),
    .sync           (sync),
    .arm            (arm),
    .clear          (clear),
    .force_trig     (force_trig),
    .post_len       (post_len),
    .trig_en        (trig_en),
    .trig_sync_only (trig_sync_only),
    .trig_mask      (trig_mask),
    .trig_pat       (trig_pat),
    .rd_idx         (rd_idx),
    .rd_data        (rd_data),
    .count          (count),
    .trig_hit       (trig_hit),
    .state          (state),
    .done           (done)
  );

  always #20 clk = ~clk;

  typedef struct {
    int          sel;
    int          due;
    logic [25:0] exp;
    string       nm;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    mi;
  logic [25:0] mact;

  // Reference model: capture state, remaining post samples, hit vector and
  // the stored samples in order (oldest first, at most 64).
  int          m_st;
  int          m_rem;
  logic [1:0]  m_hit;
  logic        m_prev;
  logic [25:0] m_tr[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    mi = 0;
    while (mi < sb.size()) begin
      if (sb[mi].due <= cyc) begin
        case (sb[mi].sel)
          0:       mact = rd_data;
          1:       mact = 26'(count);
          2:       mact = 26'(state);
          3:       mact = 26'(trig_hit);
          4:       mact = 26'(done);
          default: mact = 26'(rd_data[23:8]);
        endcase
        n_chk = n_chk + 1;
        if (mact !== sb[mi].exp) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got %h expected %h (t=%0t)", sb[mi].nm, mact, sb[mi].exp, $time);
        end
        sb.delete(mi);
      end else begin
        mi = mi + 1;
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input int sel, input logic [25:0] exp, input int lat, input string nm);
    item_t it;
    it.sel = sel;
    it.exp = exp;
    it.due = cyc + lat;
    it.nm  = nm;
    sb.push_back(it);
  endtask

  task automatic model_store();
    m_tr.push_back({sync, rw, a, d});
    if (m_tr.size() > 64) void'(m_tr.pop_front());
  endtask

  task automatic model_eval();
    logic       samp;
    logic [1:0] m;
    samp = m_prev && !phi2;
    for (int i = 0; i < 2; i++)
      m[i] = trig_en[i] && (((a ^ trig_pat[i*16 +: 16]) & trig_mask[i*16 +: 16]) == 16'h0)
             && (!trig_sync_only[i] || sync);
    if (clear) begin
      m_st = 0;
      m_tr.delete();
    end else if (arm) begin
      m_st  = 1;
      m_hit = 2'b00;
      m_tr.delete();
    end else if (m_st == 1) begin
      if (samp) model_store();
      if (samp && m != 2'b00) begin
        m_hit = m;
        m_rem = int'(post_len);
        m_st  = (post_len == 0) ? 3 : 2;
      end else if (force_trig) begin
        m_hit = 2'b00;
        m_rem = int'(post_len);
        m_st  = (post_len == 0) ? 3 : 2;
      end
    end else if (m_st == 2 && samp) begin
      model_store();
      m_rem = m_rem - 1;
      if (m_rem == 0) m_st = 3;
    end
    m_prev = phi2;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic [15:0] ba, input logic bs);
    a    = ba;
    d    = 8'($urandom);
    rw   = 1'($urandom);
    sync = bs;
    phi2 = 1'b1;
    tick();
    phi2 = 1'b0;
    tick();
    if ($urandom_range(0, 2) == 0) tick();
  endtask

  task automatic pulse(input int which);
    if (which == 0) arm = 1'b1;
    else if (which == 1) clear = 1'b1;
    else force_trig = 1'b1;
    tick();
    arm        = 1'b0;
    clear      = 1'b0;
    force_trig = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    push(1, 26'(m_tr.size()), 0, {tag, ".count"});
    push(2, 26'(m_st), 0, {tag, ".state"});
    push(3, 26'(m_hit), 0, {tag, ".trig_hit"});
    push(4, 26'(m_st == 3), 0, {tag, ".done"});
  endtask

  task automatic chk_const(input int sel, input logic [25:0] exp, input string nm);
    push(sel, exp, 0, nm);
  endtask

  task automatic chk_read(input int idx, input string tag);
    rd_idx = 6'(idx);
    push(0, (idx < m_tr.size()) ? m_tr[idx] : 26'h0, 1, tag);
    tick();
  endtask

  task automatic chk_read_addr(input int idx, input logic [15:0] ea, input string tag);
    rd_idx = 6'(idx);
    push(0, (idx < m_tr.size()) ? m_tr[idx] : 26'h0, 1, {tag, ".entry"});
    push(5, 26'(ea), 1, {tag, ".addr"});
    tick();
  endtask

  initial begin
    rst_n = 1'b0; phi2 = 1'b0; a = '0; d = '0; rw = 1'b1; sync = 1'b0;
    arm = 1'b0; clear = 1'b0; force_trig = 1'b0; post_len = '0;
    trig_en = '0; trig_sync_only = '0; trig_mask = '0; trig_pat = '0; rd_idx = '0;
    m_st = 0; m_rem = 0; m_hit = 2'b00; m_prev = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state and an idle bus with no capture running.
    chk_status("reset");
    chk_const(1, 26'd0, "reset.count_const");
    for (int i = 0; i < 5; i++) bus_cycle(16'($urandom), 1'($urandom));
    chk_status("idle");
    chk_const(2, 26'd0, "idle.state_const");
    chk_read(0, "idle.rd0");
    chk_read(5, "idle.rd5");
    chk_read(63, "idle.rd63");

    // Channel-0 trigger at 0xFFFC with three post-trigger samples.
    trig_en = 2'b01; trig_mask = {16'h0000, 16'hFFFF}; trig_pat = {16'h0000, 16'hFFFC};
    post_len = 6'd3;
    pulse(0);
    for (int i = 0; i < 11; i++) bus_cycle(16'h1000 + 16'(i), 1'($urandom));
    bus_cycle(16'hFFFC, 1'($urandom));
    for (int i = 0; i < 3; i++) bus_cycle(16'h2000 + 16'(i), 1'($urandom));
    chk_const(2, 26'd3, "trig0.done_state");
    for (int i = 3; i < 5; i++) bus_cycle(16'h2000 + 16'(i), 1'($urandom));
    chk_status("trig0");
    chk_const(1, 26'd15, "trig0.count_const");
    chk_const(3, 26'b01, "trig0.hit_const");
    chk_read_addr(0, 16'h1000, "trig0.rd0");
    chk_read_addr(11, 16'hFFFC, "trig0.rd11");
    chk_read_addr(14, 16'h2002, "trig0.rd14");
    chk_read(15, "trig0.rd15");

    // Wrap-around: 100 pre-trigger samples, trigger with post_len=0.
    post_len = 6'd0;
    pulse(0);
    for (int i = 0; i < 100; i++) bus_cycle(16'h3000 + 16'(i), 1'($urandom));
    bus_cycle(16'hFFFC, 1'b0);
    chk_status("wrap");
    chk_const(1, 26'd64, "wrap.count_const");
    chk_read_addr(63, 16'hFFFC, "wrap.rd63");
    chk_read_addr(0, 16'h3025, "wrap.rd0");

    // SYNC-qualified channel 1.
    trig_en = 2'b10; trig_sync_only = 2'b10;
    trig_mask = {16'hFFFF, 16'hFFFF}; trig_pat = {16'h0300, 16'hFFFC};
    pulse(0);
    bus_cycle(16'h0300, 1'b0);
    chk_const(2, 26'd1, "sync0.armed");
    chk_status("sync0");
    bus_cycle(16'h0300, 1'b1);
    chk_const(2, 26'd3, "sync1.done");
    chk_const(3, 26'b10, "sync1.hit_const");
    chk_status("sync1");

    // Manual trigger with post_len=2.
    trig_en = 2'b00; post_len = 6'd2;
    pulse(0);
    for (int i = 0; i < 3; i++) bus_cycle(16'($urandom), 1'($urandom));
    pulse(2);
    chk_const(2, 26'd2, "force.post");
    chk_const(3, 26'd0, "force.hit_const");
    bus_cycle(16'h4000, 1'b0);
    chk_const(2, 26'd2, "force.post1");
    bus_cycle(16'h4001, 1'b0);
    chk_const(2, 26'd3, "force.done");
    chk_const(1, 26'd5, "force.count_const");
    chk_status("force");

    // clear beats a coincident arm during POST.
    post_len = 6'd5;
    pulse(0);
    bus_cycle(16'h5000, 1'b0);
    bus_cycle(16'h5001, 1'b0);
    pulse(2);
    bus_cycle(16'h5002, 1'b0);
    clear = 1'b1; arm = 1'b1;
    tick();
    clear = 1'b0; arm = 1'b0;
    chk_const(2, 26'd0, "clr.idle");
    chk_const(1, 26'd0, "clr.count0");
    bus_cycle(16'h5003, 1'b0);
    chk_status("clr.idle_bus");
    pulse(0);
    chk_const(1, 26'd0, "rearm.count0");
    for (int i = 0; i < 3; i++) bus_cycle(16'h6000 + 16'(i), 1'b0);
    chk_const(1, 26'd3, "rearm.count3");
    chk_read_addr(0, 16'h6000, "rearm.rd0");

    // Randomised traffic against the model.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) pulse(1);
      else if (r < 9) pulse(0);
      else if (r < 12) pulse(2);
      else if (r < 18) begin
        trig_en        = 2'($urandom);
        trig_sync_only = 2'($urandom);
        trig_mask      = $urandom & $urandom;
        trig_pat       = $urandom;
        post_len       = 6'($urandom_range(0, 9));
      end else if (r < 28) chk_read($urandom_range(0, 63), "rand.rd");
      else if (r < 33) chk_status("rand");
      else if (r < 50) bus_cycle(trig_pat[$urandom_range(0, 1)*16 +: 16], 1'($urandom));
      else bus_cycle(16'($urandom), 1'($urandom));
    end
    chk_status("final");
    for (int i = 0; i < 4; i++) chk_read(i * 21, "final.rd");

    repeat (3) tick();
    if (sb.size() != 0) begin
      n_chk = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL drain: got %0d pending checks expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
